// File: rtl/rua_pkg.sv
// Shared types and default timing for the two-street intersection controller.
package rua_pkg;

  typedef enum logic [2:0] {
    INIT_RED = 3'd0,
    GREEN_A  = 3'd1,
    CLR_AB   = 3'd2,
    GREEN_B  = 3'd3,
    CLR_BA   = 3'd4
  } rua_state_t;

  localparam int DEF_GREEN_MIN    = 4;
  localparam int DEF_GREEN_MAX    = 16;
  localparam int DEF_CLEAR_CYCLES = 2;

  function automatic logic is_green_a(input rua_state_t s);
    return s == GREEN_A;
  endfunction

  function automatic logic is_green_b(input rua_state_t s);
    return s == GREEN_B;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous level inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rua_a_b.sv
// Two-street intersection controller: mutually exclusive greens with
// min/max green time and an all-red clearance between greens.
module rua_a_b
  import rua_pkg::*;
#(
  parameter int GREEN_MIN    = DEF_GREEN_MIN,
  parameter int GREEN_MAX    = DEF_GREEN_MAX,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  output logic s1,
  output logic s2
);

  localparam int TW = $clog2(GREEN_MAX + 1);
  localparam logic [TW-1:0] MIN_M1 = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] MAX_M1 = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] CLR_M1 = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] T_SAT  = TW'(GREEN_MAX);

  if (GREEN_MIN < 1) begin : g_bad_min
    $error("rua_a_b: GREEN_MIN must be at least 1");
  end
  if (GREEN_MAX < GREEN_MIN) begin : g_bad_max
    $error("rua_a_b: GREEN_MAX must be at least GREEN_MIN");
  end
  if (CLEAR_CYCLES < 1 || CLEAR_CYCLES > GREEN_MAX) begin : g_bad_clr
    $error("rua_a_b: CLEAR_CYCLES must lie in 1..GREEN_MAX");
  end

  logic       a_s;
  logic       b_s;
  rua_state_t state;
  rua_state_t state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;

  sync_2ff u_sync_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (a),
    .q     (a_s)
  );

  sync_2ff u_sync_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (b),
    .q     (b_s)
  );

  // A green yields only to competing demand, and only early if its own
  // street has gone quiet; otherwise it runs to GREEN_MAX.
  always_comb begin
    state_next = state;
    case (state)
      INIT_RED: if (timer >= CLR_M1) state_next = GREEN_A;
      GREEN_A:  if (b_s && (timer >= MIN_M1) && (!a_s || (timer >= MAX_M1)))
                  state_next = CLR_AB;
      CLR_AB:   if (timer >= CLR_M1) state_next = GREEN_B;
      GREEN_B:  if (a_s && (timer >= MIN_M1) && (!b_s || (timer >= MAX_M1)))
                  state_next = CLR_BA;
      CLR_BA:   if (timer >= CLR_M1) state_next = GREEN_A;
      default:  state_next = INIT_RED;
    endcase
  end

  always_comb begin
    timer_next = timer;
    if (state_next != state) begin
      timer_next = '0;
    end else if (timer != T_SAT) begin
      timer_next = timer + TW'(1);
    end
  end

  // Lamps are decoded from the next state so they switch on the same edge
  // as the state register and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_RED;
      timer <= '0;
      s1    <= 1'b0;
      s2    <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      s1    <= is_green_a(state_next);
      s2    <= is_green_b(state_next);
    end
  end

endmodule

// File: tb/tb_rua_a_b.sv
// Self-checking bench for rua_a_b: street-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_rua_a_b;

  localparam int GMIN = 4;
  localparam int GMAX = 16;
  localparam int CLR  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic a     = 1'b0;
  logic b     = 1'b0;
  logic s1;
  logic s2;

  int vectors     = 0;
  int miscompares = 0;

  rua_a_b #(
    .GREEN_MIN    (GMIN),
    .GREEN_MAX    (GMAX),
    .CLEAR_CYCLES (CLR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .s1    (s1),
    .s2    (s2)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0b, required %0b", name, actual, expected);
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Street-level model: one street owns (or is about to own) the green,
  // and the intersection is either red (clearing / start-up) or green.
  logic       m_red     = 1'b1;
  int         m_owner   = 0;
  int         m_elapsed = 0;
  logic [1:0] m_d1      = 2'b00;
  logic [1:0] m_d2      = 2'b00;

  always @(posedge clk or negedge rst_n) begin : model
    int   cyc;
    logic own_dem;
    logic oth_dem;
    if (!rst_n) begin
      m_red     <= 1'b1;
      m_owner   <= 0;
      m_elapsed <= 0;
      m_d1      <= 2'b00;
      m_d2      <= 2'b00;
    end else begin
      cyc     = m_elapsed + 1;
      own_dem = m_d2[m_owner];
      oth_dem = m_d2[1 - m_owner];
      if (m_red) begin
        if (cyc >= CLR) begin
          m_red     <= 1'b0;
          m_elapsed <= 0;
        end else begin
          m_elapsed <= cyc;
        end
      end else if (oth_dem && cyc >= GMIN && (!own_dem || cyc >= GMAX)) begin
        m_red     <= 1'b1;
        m_owner   <= 1 - m_owner;
        m_elapsed <= 0;
      end else begin
        m_elapsed <= cyc;
      end
      m_d2 <= m_d1;
      m_d1 <= {b, a};
    end
  end

  always @(negedge clk) begin
    check_output("model_s1", s1, !m_red && m_owner == 0);
    check_output("model_s2", s2, !m_red && m_owner == 1);
    check_output("no_overlap", s1 & s2, 1'b0);
  end

  task automatic apply_stimulus(input logic na, input logic nb, input int cycles);
    a = na;
    b = nb;
    repeat (cycles) @(negedge clk);
  endtask

  int pat[80];

  function automatic int run_len(input int start, input int code);
    int n = 0;
    for (int i = start; i < 80; i++) begin
      if (pat[i] != code) break;
      n++;
    end
    return n;
  endfunction

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stim
    int idx;
    int len;
    int s1_rises;
    int s2_rises;
    int red_cycles;
    logic p1;
    logic p2;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_s1", s1, 1'b0);
    check_output("reset_s2", s2, 1'b0);

    // Start-up: two red cycles, then A holds with no demand anywhere.
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1);
    check_output("init_red1_s1", s1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1);
    check_output("init_grant_s1", s1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 40);
    check_output("hold_a_s1", s1, 1'b1);
    check_output("hold_a_s2", s2, 1'b0);

    // Demand on B with A idle: 2 sync cycles, exit on 3rd edge, 2 red, B.
    apply_stimulus(1'b0, 1'b1, 2);
    check_output("b_req_still_a", s1, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1);
    check_output("b_req_clear1_s1", s1, 1'b0);
    check_output("b_req_clear1_s2", s2, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1);
    check_output("b_req_clear2_s2", s2, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1);
    check_output("b_grant_s2", s2, 1'b1);

    // Single-cycle pulse on A while B idles: clearance still ends in A.
    apply_stimulus(1'b0, 1'b0, 20);
    apply_stimulus(1'b1, 1'b0, 1);
    apply_stimulus(1'b0, 1'b0, 1);
    check_output("pulse_still_b", s2, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1);
    check_output("pulse_clear_s2", s2, 1'b0);
    check_output("pulse_clear_s1", s1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 2);
    check_output("pulse_grant_a", s1, 1'b1);

    // Both streets demanding: fixed 16 green / 2 red alternation.
    a = 1'b1;
    b = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      pat[i] = s1 ? 1 : (s2 ? 2 : 0);
    end
    idx = 1;
    while (idx < 80 && !(pat[idx] == 2 && pat[idx-1] != 2)) idx++;
    check_int("alt_b_found", (idx < 80) ? 1 : 0, 1);
    if (idx >= 80) idx = 79;
    len = run_len(idx, 2); check_int("alt_b_len", len, GMAX);  idx += len;
    len = run_len(idx, 0); check_int("alt_red1_len", len, CLR); idx += len;
    len = run_len(idx, 1); check_int("alt_a_len", len, GMAX);  idx += len;
    len = run_len(idx, 0); check_int("alt_red2_len", len, CLR);

    // Asynchronous reset in the middle of a B green.
    apply_stimulus(1'b0, 1'b1, 30);
    check_output("pre_reset_b", s2, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_output("async_reset_s2", s2, 1'b0);
    check_output("async_reset_s1", s1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b1, 1);
    check_output("rerun_red_s1", s1, 1'b0);
    check_output("rerun_red_s2", s2, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1);
    check_output("rerun_grant_a", s1, 1'b1);

    // Sweep all demand combinations; every green and clearance must appear.
    s1_rises   = 0;
    s2_rises   = 0;
    red_cycles = 0;
    p1 = s1;
    p2 = s2;
    for (int pcode = 0; pcode < 4; pcode++) begin
      a = pcode[1];
      b = pcode[0];
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (s1 && !p1) s1_rises++;
        if (s2 && !p2) s2_rises++;
        if (!s1 && !s2) red_cycles++;
        p1 = s1;
        p2 = s2;
      end
    end
    check_int("sweep_a_granted", (s1_rises > 0) ? 1 : 0, 1);
    check_int("sweep_b_granted", (s2_rises > 0) ? 1 : 0, 1);
    check_int("sweep_cleared", (red_cycles > 0) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
